// File: rtl/adder_sum_accumulator.sv
// Block accumulator for the registered adder sum stream: sums up to COUNT samples,
// then holds total, sample count and sticky overflow until the consumer takes them.
module adder_sum_accumulator #(
    parameter int IN_WIDTH  = 34,
    parameter int ACC_WIDTH = 48,
    parameter int COUNT     = 8,
    parameter int COUNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [COUNT_W-1:0]   out_count,
    output logic                 out_ovf
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [COUNT_W-1:0]   out_count_q, out_count_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [ACC_WIDTH:0]   sample_ext;
    logic [ACC_WIDTH:0]   sum;
    logic [COUNT_W-1:0]   cnt_inc;
    logic                 accept;
    logic                 last;

    assign in_ready   = (state_q == ST_ACCUM);
    assign accept     = in_valid & in_ready;
    assign sample_ext = {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};
    assign sum        = {1'b0, acc_q} + sample_ext;
    assign cnt_inc    = cnt_q + COUNT_W'(1);
    assign last       = (cnt_inc == COUNT_W'(COUNT));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (last || flush) begin
                        // a flush arriving with a sample closes the block including it
                        out_data_d  = sum[ACC_WIDTH-1:0];
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_q | sum[ACC_WIDTH];
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ST_HOLD;
                    end else begin
                        acc_d = sum[ACC_WIDTH-1:0];
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | sum[ACC_WIDTH];
                    end
                end else if (flush && (cnt_q != '0)) begin
                    out_data_d  = acc_q;
                    out_count_d = cnt_q;
                    out_ovf_d   = ovf_q;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: directed cases plus randomized traffic checked
// against a queue-based block model, on a 48-bit and a 36-bit accumulator instance.
module tb_adder_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [33:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf;
    logic [47:0] out_data;
    logic [3:0]  out_count;
    logic        in_ready36, out_valid36, out_ovf36;
    logic [35:0] out_data36;
    logic [3:0]  out_count36;

    int total = 0;
    int bad   = 0;

    // model state: samples of the open block, and the last emitted result
    logic [33:0] blk[$];
    bit          m_hold = 1'b0;
    logic [63:0] e_data48 = '0, e_data36 = '0;
    logic [3:0]  e_cnt = '0;
    bit          e_ovf48 = 1'b0, e_ovf36 = 1'b0;

    localparam logic [33:0] ALL1 = '1;

    always #5 clk = ~clk;

    adder_sum_accumulator dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
    );

    adder_sum_accumulator #(.ACC_WIDTH(36)) dut36 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready36),
        .in_data(in_data), .flush(flush), .out_valid(out_valid36), .out_ready(out_ready),
        .out_data(out_data36), .out_count(out_count36), .out_ovf(out_ovf36)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void emit_block();
        logic [63:0] tot;
        tot = '0;
        foreach (blk[i]) tot += {30'd0, blk[i]};
        e_data48 = tot & ((64'd1 << 48) - 64'd1);
        e_ovf48  = (tot >> 48) != 64'd0;
        e_data36 = tot & ((64'd1 << 36) - 64'd1);
        e_ovf36  = (tot >> 36) != 64'd0;
        e_cnt    = 4'(blk.size());
        blk.delete();
        m_hold   = 1'b1;
    endfunction

    task automatic step(input logic v, input logic [33:0] d, input logic f,
                        input logic r, input logic rb);
        rst_n = rb; in_valid = v; in_data = d; flush = f; out_ready = r;
        if (!rb) begin
            m_hold = 1'b0;
            blk.delete();
            e_data48 = '0; e_data36 = '0; e_cnt = '0; e_ovf48 = 1'b0; e_ovf36 = 1'b0;
        end else if (m_hold) begin
            if (r) m_hold = 1'b0;
        end else if (v) begin
            blk.push_back(d);
            if (blk.size() == 8 || f) emit_block();
        end else if (f && blk.size() > 0) begin
            emit_block();
        end
        @(posedge clk);
        #1;
        check_val("out_valid", {63'd0, out_valid}, {63'd0, m_hold});
        check_val("in_ready", {63'd0, in_ready}, {63'd0, !m_hold});
        check_val("out_data", {16'd0, out_data}, e_data48);
        check_val("out_count", {60'd0, out_count}, {60'd0, e_cnt});
        check_val("out_ovf", {63'd0, out_ovf}, {63'd0, e_ovf48});
        check_val("out_valid36", {63'd0, out_valid36}, {63'd0, m_hold});
        check_val("out_data36", {28'd0, out_data36}, e_data36);
        check_val("out_ovf36", {63'd0, out_ovf36}, {63'd0, e_ovf36});
        check_val("out_count36", {60'd0, out_count36}, {60'd0, e_cnt});
    endtask

    initial begin
        logic [63:0] r64;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 34'd5, 1'b1, 1'b1, 1'b0);
        check_val("rst_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_data", {16'd0, out_data}, 64'd0);
        check_val("rst_ready", {63'd0, in_ready}, 64'd1);

        // 1..8 back to back
        for (int i = 1; i <= 8; i++) step(1'b1, 34'(i), 1'b0, 1'b1, 1'b1);
        check_val("seq_data", {16'd0, out_data}, 64'd36);
        check_val("seq_count", {60'd0, out_count}, 64'd8);
        check_val("seq_valid", {63'd0, out_valid}, 64'd1);
        check_val("seq_inready", {63'd0, in_ready}, 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check_val("seq_valid_drop", {63'd0, out_valid}, 64'd0);

        // full-scale samples: no overflow at 48 bits, overflow at 36 bits
        for (int i = 0; i < 8; i++) step(1'b1, ALL1, 1'b0, 1'b1, 1'b1);
        check_val("max_data48", {16'd0, out_data}, 64'd137438953464);
        check_val("max_ovf48", {63'd0, out_ovf}, 64'd0);
        check_val("max_data36", {28'd0, out_data36}, 64'd68719476728);
        check_val("max_ovf36", {63'd0, out_ovf36}, 64'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // flush alone, flush with a sample, flush on an empty block
        step(1'b1, 34'd5, 1'b0, 1'b1, 1'b1);
        step(1'b1, 34'd6, 1'b0, 1'b1, 1'b1);
        step(1'b1, 34'd7, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check_val("flush_data", {16'd0, out_data}, 64'd18);
        check_val("flush_count", {60'd0, out_count}, 64'd3);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 34'd5, 1'b0, 1'b1, 1'b1);
        step(1'b1, 34'd6, 1'b0, 1'b1, 1'b1);
        step(1'b1, 34'd7, 1'b0, 1'b1, 1'b1);
        step(1'b1, 34'd9, 1'b1, 1'b1, 1'b1);
        check_val("flushs_data", {16'd0, out_data}, 64'd27);
        check_val("flushs_count", {60'd0, out_count}, 64'd4);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check_val("flush_empty", {63'd0, out_valid}, 64'd0);

        // backpressure: result held, input stalled
        for (int i = 1; i <= 8; i++) step(1'b1, 34'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 34'd99, 1'b0, 1'b0, 1'b1);
            check_val("bp_valid", {63'd0, out_valid}, 64'd1);
            check_val("bp_data", {16'd0, out_data}, 64'd36);
            check_val("bp_inready", {63'd0, in_ready}, 64'd0);
        end
        step(1'b1, 34'd99, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 34'd1, 1'b0, 1'b1, 1'b1);
        check_val("bp_next_data", {16'd0, out_data}, 64'd8);
        check_val("bp_next_count", {60'd0, out_count}, 64'd8);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // reset mid-block and during HOLD
        for (int i = 0; i < 4; i++) step(1'b1, 34'd100, 1'b0, 1'b1, 1'b1);
        step(1'b1, 34'd100, 1'b1, 1'b1, 1'b0);
        check_val("rstmid_data", {16'd0, out_data}, 64'd0);
        check_val("rstmid_count", {60'd0, out_count}, 64'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 34'd1, 1'b0, 1'b1, 1'b1);
        check_val("rstmid_after", {16'd0, out_data}, 64'd8);
        check_val("rstmid_cnt8", {60'd0, out_count}, 64'd8);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("rsthold_valid", {63'd0, out_valid}, 64'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1);

        // randomized traffic
        for (int c = 0; c < 10000; c++) begin
            logic [33:0] d;
            r64 = {$urandom(), $urandom()};
            d = ($urandom_range(9, 0) == 0) ? ALL1 : r64[33:0];
            step(1'($urandom_range(9, 0) < 7), d, 1'($urandom_range(9, 0) == 0),
                 1'($urandom_range(1, 0)), 1'($urandom_range(499, 0) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
